// File: rtl/instruction_fetch_queue.sv
// Fetch stage: PC register driving a combinational imem plus an in-order fetch queue.
// Define IF_PERF_CNT_EN to add saturating fetch/stall performance counters.
module instruction_fetch_queue #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_if,
    input  logic              reset_if,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              stall_if,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt,
`endif
    output logic [ADDR_W-1:0] out_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_W / 8);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem [DEPTH];

    logic full;
    logic pop;
    logic fetch;
    logic [ADDR_W-1:0] target;

    assign imem_addr = pc_q;
    assign full      = (count == FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign fetch     = ~redirect_valid & ~stall_if & (~full | pop);
    // Redirect targets are forced onto an instruction boundary.
    assign target    = redirect_pc & ~(STEP - ADDR_W'(1));

    assign out_inst = out_valid ? inst_mem[rd_ptr] : '0;
    assign out_pc   = out_valid ? pc_mem[rd_ptr] : '0;

    always_ff @(posedge clk_if or negedge reset_if) begin
        if (!reset_if) begin
            pc_q   <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc_q   <= target;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch) begin
                pc_q   <= pc_q + STEP;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({fetch, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: out_* are gated by count.
    always_ff @(posedge clk_if) begin
        if (fetch) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= pc_q;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic blocked;

    // Blocked means stalled or full-without-pop; redirect cycles do not count.
    assign blocked = ~redirect_valid & ~fetch;

    always_ff @(posedge clk_if or negedge reset_if) begin
        if (!reset_if) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch && perf_fetch_cnt != '1) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (blocked && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
